// File: rtl/residu_filt.sv
// LP residual (inverse A(z) filter) over one subframe: y[n] = x[n] + sum a[j]*x[n-j], Q12 taps.
// Taps accumulate through the shared L_mac; the sum is scaled by L_shl and rounded by L_add.
module residu_filt #(
  parameter int unsigned L    = 40,
  parameter int unsigned M    = 10,
  parameter int unsigned HIST = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [10:0] xAddr,
  input  logic [10:0] aAddr,
  input  logic [10:0] yAddr,
  input  logic [31:0] memIn,
  output logic        memWriteEn,
  output logic [10:0] memWriteAddr,
  output logic [31:0] memOut,
  output logic        done,
  output logic [15:0] L_macOutA,
  output logic [15:0] L_macOutB,
  output logic [31:0] L_macOutC,
  input  logic [31:0] L_macIn,
  output logic [31:0] L_shlOutVar1,
  output logic [15:0] L_shlNumShiftOut,
  output logic        L_shlReady,
  input  logic        L_shlDone,
  input  logic [31:0] L_shlIn,
  output logic [31:0] L_addOutA,
  output logic [31:0] L_addOutB,
  input  logic [31:0] L_addIn
);
  localparam logic [5:0] NLast   = 6'(L - 1);
  localparam logic [3:0] JLast   = 4'(M);
  localparam logic [5:0] HistOfs = 6'(HIST);

  typedef enum logic [3:0] {
    StIdle, StSetup, StRdA, StRdX, StMac, StShlGo, StShlWait, StRound, StWrite, StDone
  } state_e;

  state_e      state_q, state_d;
  logic        wait_q, wait_d;
  logic [5:0]  n_q, n_d;
  logic [3:0]  j_q, j_d;
  logic [15:0] a_q, a_d;
  logic [31:0] acc_q, acc_d;

  logic        we_d, shl_rdy_d, done_d;
  logic [10:0] addr_d;
  logic [31:0] mout_d, mac_c_d, shl_v_d, add_a_d, add_b_d;
  logic [15:0] mac_a_d, mac_b_d, shl_n_d;

  logic unused_bits;
  assign unused_bits = ^{memIn[31:16], L_addIn[15:0], xAddr[5:0], aAddr[5:0], yAddr[5:0]};

  always_ff @(posedge clk) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone: if (start) state_d = StSetup;
      StSetup:        state_d = StRdA;
      StRdA:          if (wait_q) state_d = StRdX;
      StRdX:          if (wait_q) state_d = StMac;
      StMac:          state_d = (j_q == JLast) ? StShlGo : StRdA;
      StShlGo:        state_d = StShlWait;
      StShlWait:      if (L_shlDone) state_d = StRound;
      StRound:        state_d = StWrite;
      StWrite:        state_d = (n_q == NLast) ? StDone : StSetup;
      default:        state_d = StIdle;
    endcase
  end

  // Datapath next-state plus output next-values keyed on the state being entered,
  // so every output register already holds its value during that state.
  always_comb begin
    wait_d    = 1'b0;
    n_d       = n_q;
    j_d       = j_q;
    a_d       = a_q;
    acc_d     = acc_q;
    case (state_q)
      StIdle, StDone: if (start) n_d = '0;
      StSetup: begin
        j_d   = '0;
        acc_d = '0;
      end
      StRdA: begin
        wait_d = ~wait_q;
        if (wait_q) a_d = memIn[15:0];
      end
      StRdX:   wait_d = ~wait_q;
      StMac: begin
        acc_d = L_macIn;
        j_d   = j_q + 4'd1;
      end
      StWrite: n_d = n_q + 6'd1;
      default: ;
    endcase

    we_d      = 1'b0;
    shl_rdy_d = 1'b0;
    done_d    = (state_d == StDone);
    addr_d    = memWriteAddr;
    mout_d    = memOut;
    mac_a_d   = L_macOutA;
    mac_b_d   = L_macOutB;
    mac_c_d   = L_macOutC;
    shl_v_d   = L_shlOutVar1;
    shl_n_d   = L_shlNumShiftOut;
    add_a_d   = L_addOutA;
    add_b_d   = L_addOutB;
    case (state_d)
      StRdA: addr_d = {aAddr[10:6], 2'b00, j_d};
      StRdX: addr_d = {xAddr[10:6], HistOfs + n_q - {2'b00, j_q}};
      StMac: begin
        mac_a_d = a_q;
        mac_b_d = memIn[15:0];
        mac_c_d = acc_q;
      end
      StShlGo: begin
        shl_v_d   = acc_d;
        shl_n_d   = 16'd3;
        shl_rdy_d = 1'b1;
      end
      StRound: begin
        add_a_d = L_shlIn;
        add_b_d = 32'h0000_8000;
      end
      StWrite: begin
        we_d   = 1'b1;
        addr_d = {yAddr[10:6], n_q};
        mout_d = {16'd0, L_addIn[31:16]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_q           <= 1'b0;
      n_q              <= '0;
      j_q              <= '0;
      a_q              <= '0;
      acc_q            <= '0;
      memWriteEn       <= 1'b0;
      memWriteAddr     <= '0;
      memOut           <= '0;
      done             <= 1'b0;
      L_macOutA        <= '0;
      L_macOutB        <= '0;
      L_macOutC        <= '0;
      L_shlOutVar1     <= '0;
      L_shlNumShiftOut <= '0;
      L_shlReady       <= 1'b0;
      L_addOutA        <= '0;
      L_addOutB        <= '0;
    end else begin
      wait_q           <= wait_d;
      n_q              <= n_d;
      j_q              <= j_d;
      a_q              <= a_d;
      acc_q            <= acc_d;
      memWriteEn       <= we_d;
      memWriteAddr     <= addr_d;
      memOut           <= mout_d;
      done             <= done_d;
      L_macOutA        <= mac_a_d;
      L_macOutB        <= mac_b_d;
      L_macOutC        <= mac_c_d;
      L_shlOutVar1     <= shl_v_d;
      L_shlNumShiftOut <= shl_n_d;
      L_shlReady       <= shl_rdy_d;
      L_addOutA        <= add_a_d;
      L_addOutB        <= add_b_d;
    end
  end

endmodule
